// File: rtl/afifo_write_ctrl_if.sv
// Write-side bus of the async FIFO controller.
// The producer drives the master side and the controller the slave side.
interface afifo_write_ctrl_if #(
    parameter int ADDRESS_SIZE = 5
);
    logic                    w_en;
    logic [ADDRESS_SIZE:0]   rgray_async;
    logic                    w_accept;
    logic [ADDRESS_SIZE-1:0] wadrs;
    logic [ADDRESS_SIZE:0]   wgray;
    logic                    full;
    logic                    almost_full;
    logic [ADDRESS_SIZE:0]   wfill;
    logic                    overflow;

    modport master (
        output w_en, rgray_async,
        input  w_accept, wadrs, wgray, full,
        input  almost_full, wfill, overflow
    );

    modport slave (
        input  w_en, rgray_async,
        output w_accept, wadrs, wgray, full,
        output almost_full, wfill, overflow
    );
endinterface

// File: rtl/afifo_write_ctrl.sv
// Async FIFO write-side controller (wclk domain).
// Define AFIFO_WOVERFLOW_EN to build the sticky overflow flag.
module afifo_write_ctrl #(
    parameter int ADDRESS_SIZE = 5,
    parameter int AF_THRESH    = 28
) (
    input logic               wclk,
    input logic               reset,
    afifo_write_ctrl_if.slave bus
);
    localparam int AW = ADDRESS_SIZE;
    localparam int PW = ADDRESS_SIZE + 1;
    localparam logic [AW:0] AF_LIM = PW'(AF_THRESH);

    logic [AW:0] wbin;
    logic [AW:0] wgray;
    logic [AW:0] rq1;
    logic [AW:0] rq2;
    logic [AW:0] rbin;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] fill_next;
    logic [AW:0] full_cmp;
    logic        accept;
    logic        full;
    logic        almost_full;
    logic [AW:0] wfill;

    assign accept = bus.w_en & ~full & reset;

    always_comb begin
        wbin_next  = wbin + PW'(accept);
        wgray_next = wbin_next ^ (wbin_next >> 1);
        rbin       = '0;
        for (int i = 0; i <= AW; i++) begin
            rbin[i] = ^(rq2 >> i);
        end
        fill_next = wbin_next - rbin;
        // Full: write pointer one lap ahead of the synchronized read pointer
        full_cmp  = {~rq2[AW:AW-1], rq2[AW-2:0]};
    end

    always_ff @(posedge wclk) begin
        if (!reset) begin
            wbin        <= '0;
            wgray       <= '0;
            rq1         <= '0;
            rq2         <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wfill       <= '0;
        end else begin
            wbin        <= wbin_next;
            wgray       <= wgray_next;
            rq1         <= bus.rgray_async;
            rq2         <= rq1;
            full        <= (wgray_next == full_cmp);
            almost_full <= (fill_next >= AF_LIM);
            wfill       <= fill_next;
        end
    end

`ifdef AFIFO_WOVERFLOW_EN
    logic overflow;

    always_ff @(posedge wclk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow | (bus.w_en & full);
        end
    end

    assign bus.overflow = overflow;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.w_accept    = accept;
    assign bus.wadrs       = wbin[AW-1:0];
    assign bus.wgray       = wgray;
    assign bus.full        = full;
    assign bus.almost_full = almost_full;
    assign bus.wfill       = wfill;
endmodule

// File: tb/tb_afifo_write_ctrl.sv
// Directed bench for afifo_write_ctrl: reset, fill, release,
// wrap-around with a trailing reader, almost-full and overflow.
module tb_afifo_write_ctrl;
    logic wclk;
    logic reset;
    int   checks;
    int   failures;
    logic ovf_on;

    afifo_write_ctrl_if #(.ADDRESS_SIZE(5)) bus ();

    afifo_write_ctrl #(
        .ADDRESS_SIZE(5),
        .AF_THRESH   (28)
    ) dut (
        .wclk (wclk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [5:0] gray(input int v);
        logic [5:0] b;
        b = v[5:0];
        return b ^ (b >> 1);
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
`ifdef AFIFO_WOVERFLOW_EN
        ovf_on = 1'b1;
`else
        ovf_on = 1'b0;
`endif
        reset           = 1'b0;
        bus.w_en        = 1'b1;
        bus.rgray_async = 6'b000101;
        #1;
        check("rst_accept", 32'(bus.w_accept), 0);
        step();
        step();
        check("rst_wadrs", 32'(bus.wadrs), 0);
        check("rst_wgray", 32'(bus.wgray), 0);
        check("rst_full", 32'(bus.full), 0);
        check("rst_af", 32'(bus.almost_full), 0);
        check("rst_wfill", 32'(bus.wfill), 0);
        check("rst_ovf", 32'(bus.overflow), 0);

        // Fill to full with the reader parked at 0
        bus.rgray_async = '0;
        step();
        reset = 1'b1;
        #1;
        for (int k = 1; k <= 32; k++) begin
            check("fill_accept", 32'(bus.w_accept), 1);
            step();
            check("fill_wfill", 32'(bus.wfill), 32'(k));
            check("fill_wadrs", 32'(bus.wadrs), 32'(k % 32));
            check("fill_wgray", 32'(bus.wgray), 32'(gray(k)));
            check("fill_full", 32'(bus.full), 32'(k == 32));
            check("fill_af", 32'(bus.almost_full), 32'(k >= 28));
        end
        check("full_wgray", 32'(bus.wgray), 32'h30);

        check("push_full_accept", 32'(bus.w_accept), 0);
        step();
        check("push_full_wadrs", 32'(bus.wadrs), 0);
        check("push_full_wgray", 32'(bus.wgray), 32'h30);
        check("push_full_wfill", 32'(bus.wfill), 32);
        check("push_full_full", 32'(bus.full), 1);
        check("push_full_ovf", 32'(bus.overflow), 32'(ovf_on));

        // Reader advances to 4: three edges to release full
        bus.w_en        = 1'b0;
        bus.rgray_async = 6'b000110;
        step();
        check("rel_full_e1", 32'(bus.full), 1);
        step();
        check("rel_full_e2", 32'(bus.full), 1);
        step();
        check("rel_full_e3", 32'(bus.full), 0);
        check("rel_wfill", 32'(bus.wfill), 28);
        check("rel_af", 32'(bus.almost_full), 1);
        check("rel_ovf", 32'(bus.overflow), 32'(ovf_on));

        reset = 1'b0;
        step();
        check("rst2_ovf", 32'(bus.overflow), 0);
        check("rst2_wfill", 32'(bus.wfill), 0);
        check("rst2_full", 32'(bus.full), 0);

        // Wrap-around: 8 preload writes, then a reader 8 behind
        reset           = 1'b1;
        bus.rgray_async = '0;
        bus.w_en        = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("pre_wfill", 32'(bus.wfill), 32'(k));
        end
        for (int e = -2; e <= 55; e++) begin
            bus.rgray_async = gray(e + 3);
            bus.w_en        = (e >= 0);
            step();
            check("wrap_wfill", 32'(bus.wfill), 8);
            check("wrap_full", 32'(bus.full), 0);
            check("wrap_af", 32'(bus.almost_full), 0);
            if (e >= 0)
                check("wrap_wadrs", 32'(bus.wadrs), 32'((9 + e) % 32));
        end
        check("wrap_end_wgray", 32'(bus.wgray), 0);
        check("wrap_end_wadrs", 32'(bus.wadrs), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/afifo_write_ctrl.md
Name: afifo_write_ctrl

Overview:
- Write-side controller for the async FIFO, in the wclk domain.
- Owns the write pointer and drives the write address and write strobe into the dual-port storage array.
- Publishes a Gray-coded write pointer to the read domain.
- Brings the read domain's Gray pointer across with a 2-flop synchronizer and uses it to generate full, fill level and almost-full.

Parameters:
- ADDRESS_SIZE, 5, storage address width; FIFO depth DEPTH = 2**ADDRESS_SIZE; pointers are ADDRESS_SIZE+1 bits.
- AF_THRESH, 28, almost_full asserts when wfill >= AF_THRESH; legal range 1..DEPTH.

Ports:
- wclk  input  1  write clock
- reset  input  1  synchronous, active-low reset
- w_en  input  1  push request from producer
- rgray_async  input  ADDRESS_SIZE+1  Gray read pointer from the rclk domain, asynchronous to wclk
- w_accept  output  1  combinational w_en & ~full & reset; storage write strobe
- wadrs  output  ADDRESS_SIZE  storage write address (= wbin[ADDRESS_SIZE-1:0])
- wgray  output  ADDRESS_SIZE+1  registered Gray write pointer, to read-domain synchronizer
- full  output  1  registered FIFO-full flag
- almost_full  output  1  registered, wfill >= AF_THRESH
- wfill  output  ADDRESS_SIZE+1  registered occupancy as seen from the write side, 0..DEPTH
- overflow  output  1  sticky overflow error (see Optional Feature)

Behaviour:
- Reset (reset=0 at a wclk edge) clears the following to 0: wbin, wgray, rq1, rq2, full, almost_full, wfill, overflow.
  - w_en is ignored during reset.
  - Reset mid-operation discards all pointer state the same edge.
  - Flushing the read side is the system's responsibility; both domains are reset together.
- Synchronizer: rq1 <= rgray_async; rq2 <= rq1. Only rq2 is used downstream; rgray_async feeds no other logic.
- Accept: w_accept = w_en & ~full & reset.
  - The storage array captures wdata at wadrs on the same edge.
- Pointer update on accept:
  - wbin_next = wbin + 1, modulo 2**(ADDRESS_SIZE+1), with natural wrap.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - Without accept, both pointers hold.
  - wadrs advances the edge after each accept; the first write goes to address 0.
- Full:
  - full <= (wgray_next == {~rq2[MSB:MSB-1], rq2[MSB-2:0]}).
  - Evaluated every edge, so full asserts on the same edge as the write that fills the last slot.
- Fill:
  - rbin = Gray-to-binary(rq2).
  - wfill <= (wbin_next - rbin) mod 2**(ADDRESS_SIZE+1).
  - almost_full <= ((wbin_next - rbin) >= AF_THRESH).
- Pessimism: rq2 lags the true read pointer by at least 2 wclk.
  - full, almost_full and wfill may stay high/over-report after reads.
  - They never under-report. This is the required, safe behaviour.
- Release latency: a read-pointer change on rgray_async clears full at the 3rd wclk edge (rq1, rq2, then the flag).
- Simultaneous w_en with rq2 advancing in the same cycle: full and wfill are computed from both the new wbin and the new rq2.
- w_en while full: no accept; pointers and storage are unchanged.
- rgray_async must change by at most one bit per rclk. Gray discipline is the read side's obligation.

Optional Feature:
- Macro: AFIFO_WOVERFLOW_EN.
- Defined: overflow <= overflow | (w_en & full & reset). It is sticky and cleared only by reset; it flags a producer writing while full.
- Not defined: the overflow port is still present and tied to constant 0; no overflow logic is built.

Test Plan:
- Reset: reset=0 for 2 edges with w_en=1 and rgray_async=6'b000101 -> wadrs=0, wgray=0, full=0, almost_full=0, wfill=0, overflow=0.
- Fill to full (depth 32, rgray_async=0, w_en=1 continuous):
  - wfill counts 1..32.
  - On the 32nd accept edge: full=1, wgray=6'b110000, wadrs=0.
  - The 33rd cycle has w_accept=0 and the pointer is unchanged.
- Release: with the FIFO full, set rgray_async=6'b000110 (binary 4) -> full stays 1 for 2 edges, then full=0 and wfill=28 after the 3rd edge.
- Wrap-around: run 64 accepted writes with the read pointer trailing by 8 -> wadrs wraps 31->0 twice and wgray returns to 6'b000000; full never asserts and wfill stays 8.
- Almost-full (AF_THRESH=28, rgray_async=0) -> almost_full=0 after 27 writes and =1 after the 28th; full=0 until the 32nd.
- Overflow with AFIFO_WOVERFLOW_EN:
  - Hold w_en=1 one cycle past full -> overflow=1 and stays 1 after full clears; reset clears it.
  - Without the macro, overflow stays 0.
